muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the execute stage, beside the ALU. It takes the same srca/srcb operand buses that feed the ALU.
- Its HI/LO outputs are muxed with the ALU result before writeback, for mfhi/mflo.
- Implements mult, multu, div, divu with radix-2 shift-add / restoring-subtract, plus mthi/mtlo writes.
- Stalls the pipeline through busy while an operation is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNTW, 6, iteration counter width; must hold WIDTH+1.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  begin operation; sampled only in IDLE
- op  input  2  00 multu, 01 mult, 10 divu, 11 div
- a  input  WIDTH  srca: multiplicand / dividend
- b  input  WIDTH  srcb: multiplier / divisor
- wr_hi  input  1  mthi: load hi from a (IDLE only)
- wr_lo  input  1  mtlo: load lo from a (IDLE only)
- busy  output  1  operation in flight; controller stalls while high
- done  output  1  one-cycle pulse when hi/lo receive a result
- divzero  output  1  last div/divu had b==0; sticky until next start
- hi  output  WIDTH  product[63:32] / remainder
- lo  output  WIDTH  product[31:0] / quotient

Behaviour:
- Reset, async, active-high. Forces:
  - state=IDLE, hi=0, lo=0, busy=0, done=0, divzero=0, counter=0.
  - This applies mid-operation too: partial results are discarded.
- States: IDLE, RUN, FIX.
- IDLE with start=1 at edge E:
  - Latch op, |a|, |b|. Magnitudes are taken only for signed ops (mult, div).
  - Latch result-sign flags: product sign = a[31]^b[31]; quotient sign = a[31]^b[31]; remainder sign = a[31].
  - Clear divzero; counter=0.
  - Go to RUN; busy=1 from E onward.
- Division by zero (div/divu with b==0) at start:
  - Go straight to FIX; no iterations.
  - Result: hi=a (original, unsigned view), lo=32'hFFFFFFFF, divzero=1.
- RUN: one iteration per clock, exactly WIDTH iterations; counter increments.
  - Multiply: if multiplier LSB=1, add multiplicand to upper accumulator; then shift the 64-bit {acc,multiplier} right by 1, carry included.
  - Divide: shift {rem,quot} left by 1; if rem>=divisor, subtract and set quot LSB=1.
  - After iteration WIDTH-1, go to FIX.
- FIX, one cycle:
  - Apply sign correction (two's-complement negate where flagged).
  - Write hi/lo; go to IDLE; busy=0, done=1 for that single following cycle.
- Latency: busy high for exactly WIDTH+1 = 33 cycles (1 cycle for divide-by-zero). hi/lo are valid the cycle done=1 and hold until the next write.
- Signed divide:
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - -2^31 / -1 gives lo=32'h80000000, hi=0, with no flag.
- start while busy: ignored. wr_hi/wr_lo while busy: ignored.
- start and wr_hi/wr_lo in the same IDLE cycle: start wins; the writes are dropped.
- wr_hi and wr_lo together: both registers load a.
- hi/lo are unchanged during RUN; intermediates live in internal registers.
- done never coincides with busy=1.

Test Plan:
- Reset mid-RUN: start multu a=5,b=7; assert reset at cycle 10 → immediately busy=0, done=0, hi=lo=0; no done pulse afterwards.
- multu a=32'hFFFFFFFF, b=32'hFFFFFFFF → busy high 33 cycles, then done pulse; hi=32'hFFFFFFFE, lo=32'h00000001.
- mult a=-3 (32'hFFFFFFFD), b=7 → hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
- div a=-7, b=2 → lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1).
- div a=32'h80000000, b=-1 → lo=32'h80000000, hi=0.
- divu a=100, b=0 → busy 1 cycle, done pulse; divzero=1, hi=100, lo=32'hFFFFFFFF.
- Busy interactions: start and wr_lo both pulsed during RUN → ignored, result unchanged; afterwards wr_hi with a=32'h1234 in IDLE → hi=32'h1234 next cycle, lo unchanged, no done pulse.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide beside the ALU.
// Shift-add multiply and restoring divide, one iteration per clock,
// with sign correction in a final FIX cycle and mthi/mtlo writes in IDLE.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    output logic             busy,
    output logic             done,
    output logic             divzero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t           r_state;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_acc;    // product upper half / partial remainder
    logic [WIDTH-1:0] r_mq;     // multiplier / dividend-then-quotient
    logic [WIDTH-1:0] r_opnd;   // multiplicand / divisor magnitude
    logic [CNTW-1:0]  r_cnt;
    logic             r_nsign;  // negate product or quotient in FIX
    logic             r_rsign;  // negate remainder in FIX
    logic             r_dz;     // current divide had a zero divisor
    logic             r_busy;
    logic             r_done;
    logic             r_divz;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_signed;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH:0]   w_madd;
    logic [WIDTH:0]   w_rsh;
    logic [WIDTH:0]   w_rsub;
    logic             w_ge;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;

    // Operand magnitudes only matter for the signed ops (op[0]=1).
    assign w_signed = op[0];
    assign w_abs_a  = (w_signed && a[WIDTH-1]) ? -a : a;
    assign w_abs_b  = (w_signed && b[WIDTH-1]) ? -b : b;

    // Multiply step: conditional add keeps the carry in bit WIDTH for the shift.
    assign w_madd = {1'b0, r_acc} + {1'b0, (r_mq[0] ? r_opnd : {WIDTH{1'b0}})};

    // Divide step: shifted remainder is one bit wider than the divisor.
    assign w_rsh  = {r_acc, r_mq[WIDTH-1]};
    assign w_ge   = (w_rsh >= {1'b0, r_opnd});
    assign w_rsub = w_rsh - {1'b0, r_opnd};

    assign w_prod     = {r_acc, r_mq};
    assign w_prod_fix = r_nsign ? -w_prod : w_prod;
    assign w_q_fix    = r_nsign ? -r_mq : r_mq;
    assign w_r_fix    = r_rsign ? -r_acc : r_acc;

    // Control FSM and datapath registers; hi/lo only change on IDLE writes or FIX.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_op    <= 2'b00;
            r_acc   <= '0;
            r_mq    <= '0;
            r_opnd  <= '0;
            r_cnt   <= '0;
            r_nsign <= 1'b0;
            r_rsign <= 1'b0;
            r_dz    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_divz  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op    <= op;
                        r_cnt   <= '0;
                        r_divz  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_nsign <= w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_rsign <= w_signed & op[1] & a[WIDTH-1];
                        if (op[1]) begin
                            r_mq   <= w_abs_a;
                            r_opnd <= w_abs_b;
                        end else begin
                            r_mq   <= w_abs_b;
                            r_opnd <= w_abs_a;
                        end
                        if (op[1] && (b == '0)) begin
                            // Keep the raw dividend for hi; skip the iterations.
                            r_acc   <= a;
                            r_dz    <= 1'b1;
                            r_state <= S_FIX;
                        end else begin
                            r_acc   <= '0;
                            r_dz    <= 1'b0;
                            r_state <= S_RUN;
                        end
                    end else begin
                        if (wr_hi) r_hi <= a;
                        if (wr_lo) r_lo <= a;
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_op[1]) begin
                        r_acc <= w_ge ? w_rsub[WIDTH-1:0] : w_rsh[WIDTH-1:0];
                        r_mq  <= {r_mq[WIDTH-2:0], w_ge};
                    end else begin
                        r_acc <= w_madd[WIDTH:1];
                        r_mq  <= {w_madd[0], r_mq[WIDTH-1:1]};
                    end
                    if (r_cnt == CNTW'(WIDTH-1)) r_state <= S_FIX;
                end
                S_FIX: begin
                    if (r_dz) begin
                        r_hi   <= r_acc;
                        r_lo   <= '1;
                        r_divz <= 1'b1;
                    end else if (r_op[1]) begin
                        r_hi <= w_r_fix;
                        r_lo <= w_q_fix;
                    end else begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign divzero = r_divz;
    assign hi      = r_hi;
    assign lo      = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random ops against an arithmetic reference model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        wr_hi = 1'b0;
    logic        wr_lo = 1'b0;
    logic        busy, done, divzero;
    logic [31:0] hi, lo;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] mhi = '0;
    logic [31:0] mlo = '0;

    muldiv_unit #(.WIDTH(32), .CNTW(6)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .wr_hi(wr_hi), .wr_lo(wr_lo), .busy(busy), .done(done),
        .divzero(divzero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural operands.
    task automatic model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] eh, output logic [31:0] el, output logic ed);
        longint sx, sy, q, r;
        logic [63:0] p;
        ed = 1'b0;
        if (o[1] && y == 32'd0) begin
            eh = x; el = 32'hFFFFFFFF; ed = 1'b1;
        end else begin
            if (o[0]) begin sx = $signed(x); sy = $signed(y); end
            else begin sx = longint'({32'd0, x}); sy = longint'({32'd0, y}); end
            if (!o[1]) begin
                p = 64'(sx * sy);
                eh = p[63:32]; el = p[31:0];
            end else begin
                q = sx / sy; r = sx % sy;
                eh = 32'(r); el = 32'(q);
            end
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit inj, input bit wr_same);
        logic [31:0] eh, el, ph, pl;
        logic ed;
        int n;
        model(o, x, y, eh, el, ed);
        ph = hi; pl = lo;
        start = 1'b1; op = o; a = x; b = y; wr_lo = wr_same;
        @(negedge clk);
        start = 1'b0; wr_lo = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            if (n == 1) chk("lo_first", lo, pl);
            if (n == 10 && inj) begin start = 1'b1; wr_lo = 1'b1; a = $urandom; end
            if (n == 11) begin start = 1'b0; wr_lo = 1'b0; end
            if (n == 16) begin
                chk("hi_run", hi, ph);
                chk("lo_run", lo, pl);
                chk("done_run", {31'd0, done}, 32'd0);
            end
            @(negedge clk);
        end
        chk("busy_len", 32'(n), ed ? 32'd1 : 32'd33);
        chk("done", {31'd0, done}, 32'd1);
        chk("hi", hi, eh);
        chk("lo", lo, el);
        chk("divzero", {31'd0, divzero}, {31'd0, ed});
        mhi = eh; mlo = el;
        @(negedge clk);
        chk("done_after", {31'd0, done}, 32'd0);
    endtask

    initial begin
        int seen;
        logic [31:0] v;
        #2 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_dz", {31'd0, divzero}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);

        // Reset in the middle of an operation discards everything.
        start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_hi", hi, 32'd0);
        chk("mid_rst_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        mhi = '0; mlo = '0;
        seen = 0;
        repeat (40) begin @(negedge clk); if (done) seen++; end
        chk("mid_rst_nodone", 32'(seen), 32'd0);

        run_op(2'b01, 32'hFFFFFFFD, 32'd7, 0, 0);
        run_op(2'b11, 32'hFFFFFFF9, 32'd2, 0, 0);
        run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 0, 0);
        run_op(2'b10, 32'd100, 32'd0, 0, 0);
        run_op(2'b11, 32'hFFFFFF00, 32'd0, 0, 0);
        run_op(2'b10, 32'd100, 32'd7, 1, 0);
        run_op(2'b00, 32'h12345678, 32'h9ABCDEF0, 0, 1);

        for (int i = 0; i < 30; i++) begin
            logic [1:0] o;
            logic [31:0] x, y;
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            y = $urandom;
            if ($urandom_range(0, 3) == 0) y = 32'($urandom_range(0, 9)) - 32'd4;
            run_op(o, x, y, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        end

        // mthi in IDLE: hi loads, lo untouched, no done pulse.
        a = 32'h1234; wr_hi = 1'b1;
        @(negedge clk);
        wr_hi = 1'b0;
        chk("mthi_hi", hi, 32'h1234);
        chk("mthi_lo", lo, mlo);
        chk("mthi_done", {31'd0, done}, 32'd0);
        mhi = 32'h1234;

        // mthi and mtlo together both load a.
        v = $urandom;
        a = v; wr_hi = 1'b1; wr_lo = 1'b1;
        @(negedge clk);
        wr_hi = 1'b0; wr_lo = 1'b0;
        chk("both_hi", hi, v);
        chk("both_lo", lo, v);
        chk("both_busy", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
